// File: rtl/segm_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: blank pattern,
// FSM state encodings and width helpers.
package segm_scan_ctrl_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_ON   = 2'd2;
  localparam state_t ST_GAP  = 2'd3;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // The timer must be able to hold the longer of the lit and dead phases.
  function automatic int timerWidth(input int clkDiv, input int blankCyc);
    return $clog2(maxInt(clkDiv, blankCyc) + 1);
  endfunction

  function automatic int idxWidth(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/segm_scan_ctrl_hex2s.sv
// Hex nibble to active-low seven-segment pattern (gfedcba), shared by all digits.
module hex2s
  import segm_scan_ctrl_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (hex_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/segm_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display,
// with per-frame value snapshot, dead-time gaps and leading-zero suppression.
module segm_scan_ctrl
  import segm_scan_ctrl_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  lz_en,
  input  logic                  en,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            segm,
  output logic                  frame_done
);

  localparam int TW = timerWidth(CLK_DIV, BLANK_CYC);
  localparam int IW = idxWidth(DIGITS);

  localparam logic [TW-1:0] ON_LAST  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [4*DIGITS-1:0]   snap_q, snap_d;
  logic [DIGITS-1:0]     dark_q, dark_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [6:0]            segm_q, segm_d;
  logic                  frameDone_q, frameDone_d;

  logic [DIGITS-1:0]     supp;
  logic                  allZero;
  logic [3:0]            curNibble;
  logic [6:0]            hexSeg;
  logic                  lit;

  // A digit is suppressed when it and every more-significant nibble are zero.
  always_comb begin
    supp    = '0;
    allZero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      allZero = allZero & (value[4*i +: 4] == 4'h0);
      supp[i] = lz_en & allZero;
    end
  end

  assign curNibble = snap_q[{idx_q, 2'b00} +: 4];

  hex2s u_hex2s (
    .hex_i (curNibble),
    .seg_o (hexSeg)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    snap_d      = snap_q;
    dark_d      = dark_q;
    frameDone_d = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_LOAD;
        ST_LOAD: begin
          snap_d  = value;
          dark_d  = blank_mask | supp;
          idx_d   = '0;
          timer_d = '0;
          state_d = ST_ON;
        end
        ST_ON: begin
          if (timer_q == ON_LAST) begin
            timer_d = '0;
            state_d = ST_GAP;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (timer_q == GAP_LAST) begin
            timer_d = '0;
            if (idx_q == IDX_LAST) begin
              frameDone_d = 1'b1;
              state_d     = ST_LOAD;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = ST_ON;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs follow the current state so an and segm always switch together.
  always_comb begin
    lit    = (state_q == ST_ON) && !dark_q[idx_q];
    an_d   = '1;
    segm_d = SEG_BLANK;
    if (lit) begin
      an_d[idx_q] = 1'b0;
      segm_d      = hexSeg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      timer_q     <= '0;
      snap_q      <= '0;
      dark_q      <= '0;
      an_q        <= '1;
      segm_q      <= SEG_BLANK;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      snap_q      <= snap_d;
      dark_q      <= dark_d;
      an_q        <= an_d;
      segm_q      <= segm_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign an         = an_q;
  assign segm       = segm_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_segm_scan_ctrl.sv
// Directed bench for segm_scan_ctrl with DIGITS=4, CLK_DIV=4, BLANK_CYC=2
// (25-cycle frame); every output cycle is compared against hand-derived values.
module tb_segm_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  blankMask;
  logic        lzEn;
  logic        en;
  logic [3:0]  an;
  logic [6:0]  segm;
  logic        frameDone;

  int checks = 0;
  int errors = 0;

  segm_scan_ctrl #(
    .DIGITS    (4),
    .CLK_DIV   (4),
    .BLANK_CYC (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .blank_mask (blankMask),
    .lz_en      (lzEn),
    .en         (en),
    .an         (an),
    .segm       (segm),
    .frame_done (frameDone)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [3:0] anExp, input logic [6:0] segExp,
                          input logic fdExp);
    checkOutput({tag, " an"}, 32'(an), 32'(anExp));
    checkOutput({tag, " segm"}, 32'(segm), 32'(segExp));
    checkOutput({tag, " frame_done"}, 32'(frameDone), 32'(fdExp));
  endtask

  // One digit slot: 4 lit (or dark) cycles followed by a 2-cycle gap.
  task automatic applyStimulus(input string tag, input logic [3:0] anExp, input logic [6:0] segExp,
                               input logic last);
    for (int c = 0; c < 4; c++) begin
      tick();
      checkAll($sformatf("%s on%0d", tag, c), anExp, segExp, 1'b0);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      checkAll($sformatf("%s gap%0d", tag, c), 4'hF, 7'h7F, last && (c == 1));
    end
  endtask

  task automatic checkLoad(input string tag);
    tick();
    checkAll(tag, 4'hF, 7'h7F, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b1;
    value     = 16'h12A0;
    blankMask = 4'h0;
    lzEn      = 1'b0;

    for (int c = 0; c < 3; c++) begin
      tick();
      checkAll($sformatf("reset%0d", c), 4'hF, 7'h7F, 1'b0);
    end
    rst = 1'b0;
    checkLoad("post-reset idle");
    checkLoad("post-reset load");

    // Frame A: 12A0 while 1111 is queued for the next snapshot.
    value = 16'h1111;
    applyStimulus("A d0", 4'b1110, 7'b1000000, 1'b0);
    applyStimulus("A d1", 4'b1101, 7'b0001000, 1'b0);
    applyStimulus("A d2", 4'b1011, 7'b0100100, 1'b0);
    applyStimulus("A d3", 4'b0111, 7'b1111001, 1'b1);
    checkLoad("A load");

    // Frame B: 1111, value changes to 2222 as digit 1 starts.
    applyStimulus("B d0", 4'b1110, 7'b1111001, 1'b0);
    value = 16'h2222;
    applyStimulus("B d1", 4'b1101, 7'b1111001, 1'b0);
    applyStimulus("B d2", 4'b1011, 7'b1111001, 1'b0);
    applyStimulus("B d3", 4'b0111, 7'b1111001, 1'b1);
    checkLoad("B load");

    // Frame C: 2222; queue 0030 with suppression.
    applyStimulus("C d0", 4'b1110, 7'b0100100, 1'b0);
    value = 16'h0030;
    lzEn  = 1'b1;
    applyStimulus("C d1", 4'b1101, 7'b0100100, 1'b0);
    applyStimulus("C d2", 4'b1011, 7'b0100100, 1'b0);
    applyStimulus("C d3", 4'b0111, 7'b0100100, 1'b1);
    checkLoad("C load");

    // Frame D: 0030 suppressed -> digits 2,3 dark; queue 0000.
    applyStimulus("D d0", 4'b1110, 7'b1000000, 1'b0);
    value = 16'h0000;
    applyStimulus("D d1", 4'b1101, 7'b0110000, 1'b0);
    applyStimulus("D d2", 4'hF, 7'h7F, 1'b0);
    applyStimulus("D d3", 4'hF, 7'h7F, 1'b1);
    checkLoad("D load");

    // Frame E: 0000 suppressed -> only digit 0; queue masked 4321.
    applyStimulus("E d0", 4'b1110, 7'b1000000, 1'b0);
    value     = 16'h4321;
    lzEn      = 1'b0;
    blankMask = 4'b0101;
    applyStimulus("E d1", 4'hF, 7'h7F, 1'b0);
    applyStimulus("E d2", 4'hF, 7'h7F, 1'b0);
    applyStimulus("E d3", 4'hF, 7'h7F, 1'b1);
    checkLoad("E load");

    // Frame F: mask 0101 -> digits 1 and 3 lit; queue unmasked.
    applyStimulus("F d0", 4'hF, 7'h7F, 1'b0);
    blankMask = 4'h0;
    applyStimulus("F d1", 4'b1101, 7'b0100100, 1'b0);
    applyStimulus("F d2", 4'hF, 7'h7F, 1'b0);
    applyStimulus("F d3", 4'b0111, 7'b0011001, 1'b1);
    checkLoad("F load");

    // Frame G: abort during digit 2.
    applyStimulus("G d0", 4'b1110, 7'b1111001, 1'b0);
    applyStimulus("G d1", 4'b1101, 7'b0100100, 1'b0);
    tick();
    checkAll("G d2 on0", 4'b1011, 7'b0110000, 1'b0);
    en = 1'b0;
    tick();
    checkAll("abort lag", 4'b1011, 7'b0110000, 1'b0);
    for (int c = 0; c < 30; c++) begin
      tick();
      checkAll($sformatf("abort idle%0d", c), 4'hF, 7'h7F, 1'b0);
    end

    en = 1'b1;
    checkLoad("resume idle");
    checkLoad("resume load");
    applyStimulus("H d0", 4'b1110, 7'b1111001, 1'b0);
    applyStimulus("H d1", 4'b1101, 7'b0100100, 1'b0);
    applyStimulus("H d2", 4'b1011, 7'b0110000, 1'b0);
    applyStimulus("H d3", 4'b0111, 7'b0011001, 1'b1);
    checkLoad("H load");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
